mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its load/store port. It grants one requester at a time and holds the memory request and payload stable until the memory acknowledges. It returns registered read data with a one-cycle ready pulse and drives a pipeline stall while either port waits. It sits between the pipeline CPU and the memory model or bus.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 72 +++++++
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the fetch/data memory arbiter:
//   - FSM state encoding (IDLE, FETCH, DATA, RESP)
//   - bit positions inside the 4-bit size qualifier {lh, lb, sh, sb}
//   - width of the data-grant streak counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // FSM state encoding.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Bit positions in the size qualifier carried on d_size / m_size.
  localparam int SB = 0;
  localparam int SH = 1;
  localparam int LB = 2;
  localparam int LH = 3;

  // Streak counter width; holds MAX_DSTREAK values 1..15.
  localparam int STREAK_W = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Grant decision for the memory arbiter plus the data-grant streak counter.
// Data normally wins (it belongs to the older instruction), but once
// MAX_DSTREAK data grants have been made back-to-back while fetch was waiting,
// the next grant goes to fetch.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   if_req       fetch port request
//   d_req        data port request
//   grant_en     arbiter is in IDLE and may grant this cycle
//   grant_fetch  fetch wins this cycle (only while grant_en)
//   grant_data   data wins this cycle (only while grant_en)
// -----------------------------------------------------------------------------
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_fetch,
  output logic grant_data
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                fetch_forced;

  assign fetch_forced = if_req && (streak_q == STREAK_MAX);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    streak_d    = streak_q;
    if (grant_en) begin
      if (d_req && !fetch_forced) begin
        grant_data = 1'b1;
        // Only a data grant that actually held fetch off extends the streak.
        if (!if_req) begin
          streak_d = '0;
        end else if (streak_q >= STREAK_MAX) begin
          streak_d = STREAK_MAX;
        end else begin
          streak_d = streak_q + 1'b1;
        end
      end else if (if_req) begin
        grant_fetch = 1'b1;
        streak_d    = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// load/store port. One requester is granted at a time; the memory request and
// payload are registered on the grant edge and held until m_ack. Read data is
// registered on m_ack and the owner's ready pulses for one cycle in RESP.
// Requests are not sampled in RESP so a req still held high is not re-granted.
//
// Build option: define MEM_ARB_PERF_EN to build the 16-bit saturating
// wait-cycle counters behind perf_fetch_wait / perf_data_wait; otherwise those
// outputs are tied to zero and no counter flops exist.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   if_req/if_addr               fetch request and PC
//   if_rdata/if_ready            registered instruction, completion pulse
//   d_req/d_wr/d_addr/d_wdata    data request, store flag, address, store data
//   d_size                       {lh,lb,sh,sb} qualifiers, passed through
//   d_rdata/d_ready              registered load data, completion pulse
//   m_req/m_wr/m_addr/m_wdata    memory request and held payload
//   m_size                       size qualifiers to memory
//   m_rdata/m_ack                memory read data, completion strobe
//   pipe_stall                   either port is waiting
//   perf_fetch_wait/data_wait    wait-cycle counters (optional)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_size,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_size,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          pipe_stall,
  output logic [15:0]   perf_fetch_wait,
  output logic [15:0]   perf_data_wait
);

  logic [1:0]    state_q,    state_d;
  logic          m_req_q,    m_req_d;
  logic          m_wr_q,     m_wr_d;
  logic [AW-1:0] m_addr_q,   m_addr_d;
  logic [DW-1:0] m_wdata_q,  m_wdata_d;
  logic [3:0]    m_size_q,   m_size_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q,  d_ready_d;

  logic grant_en, grant_fetch, grant_data;

  assign grant_en = (state_q == IDLE);

  arb_pick #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_pick (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .d_req       (d_req),
    .grant_en    (grant_en),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_wr_d     = m_wr_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_size_d   = m_size_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // Ready is a one-cycle pulse: it is only ever set on the m_ack edge.
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d   = DATA;
          m_req_d   = 1'b1;
          m_wr_d    = d_wr;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_size_d  = d_size;
        end else if (grant_fetch) begin
          // m_wdata is left as-is on a fetch; memory ignores it for reads.
          state_d  = FETCH;
          m_req_d  = 1'b1;
          m_wr_d   = 1'b0;
          m_addr_d = if_addr;
          m_size_d = '0;
        end
      end
      FETCH: begin
        if (m_ack) begin
          state_d    = RESP;
          m_req_d    = 1'b0;
          if_rdata_d = m_rdata;
          if_ready_d = 1'b1;
        end
      end
      DATA: begin
        // Stores latch m_rdata too; d_rdata content is meaningless for them.
        if (m_ack) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          d_rdata_d = m_rdata;
          d_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_wr_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_size_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_wr_q     <= m_wr_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_size_q   <= m_size_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_wr     = m_wr_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_size   = m_size_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;

  assign pipe_stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_fetch_q, perf_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_data_q  <= '0;
    end else begin
      if (if_req && !if_ready_q && (perf_fetch_q != 16'hFFFF)) begin
        perf_fetch_q <= perf_fetch_q + 16'd1;
      end
      if (d_req && !d_ready_q && (perf_data_q != 16'hFFFF)) begin
        perf_data_q <= perf_data_q + 16'd1;
      end
    end
  end

  assign perf_fetch_wait = perf_fetch_q;
  assign perf_data_wait  = perf_data_q;
`else
  assign perf_fetch_wait = '0;
  assign perf_data_wait  = '0;
`endif

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A memory model answers m_req after a
// per-transaction number of wait states; expected memory payloads and
// responses are queued when stimulus is driven and consumed as the DUT
// issues requests and ready pulses.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_size;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          m_req;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_size;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          pipe_stall;
  logic [15:0]   perf_fetch_wait;
  logic [15:0]   perf_data_wait;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MAX_DSTREAK (MAXD),
    .AW          (AW),
    .DW          (DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_rdata        (if_rdata),
    .if_ready        (if_ready),
    .d_req           (d_req),
    .d_wr            (d_wr),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_size          (d_size),
    .d_rdata         (d_rdata),
    .d_ready         (d_ready),
    .m_req           (m_req),
    .m_wr            (m_wr),
    .m_addr          (m_addr),
    .m_wdata         (m_wdata),
    .m_size          (m_size),
    .m_rdata         (m_rdata),
    .m_ack           (m_ack),
    .pipe_stall      (pipe_stall),
    .perf_fetch_wait (perf_fetch_wait),
    .perf_data_wait  (perf_data_wait)
  );

  // Single-transaction vector: inputs plus the expected ready cycle (2 + waits).
  typedef struct {
    logic          fetch;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    size;
    int            waits;
    int            ready_cyc;
  } vec_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    size;
    logic          chk_wdata;
    int            waits;
  } mem_exp_t;

  typedef struct {
    logic          fetch;
    logic          chk_rdata;
    logic [DW-1:0] rdata;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];
  vec_t     vecs[6];

  int checks   = 0;
  int errors   = 0;
  bit spur_ack = 1'b0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input logic fetch, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [3:0] size, input int waits);
    mem_exp_t e;
    rsp_exp_t r;
    e.wr        = fetch ? 1'b0 : wr;
    e.addr      = addr;
    e.wdata     = wdata;
    e.size      = fetch ? 4'b0000 : size;
    e.chk_wdata = !fetch && wr;
    e.waits     = waits;
    r.fetch     = fetch;
    r.chk_rdata = fetch || !wr;
    r.rdata     = mem_rd(addr);
    mem_q.push_back(e);
    rsp_q.push_back(r);
  endtask

  // Memory model and scoreboard, sampled on the falling edge.
  initial begin
    int       wcnt;
    mem_exp_t e;
    rsp_exp_t r;
    wcnt    = 0;
    m_ack   = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_ack = 1'b0;
        wcnt  = 0;
      end else begin
        if (m_req) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_m_req addr=%0h expected no request", m_addr);
            m_ack = 1'b0;
          end else begin
            e = mem_q[0];
            check("m_addr", m_addr, e.addr);
            check("m_wr", m_wr, e.wr);
            check("m_size", m_size, e.size);
            if (e.chk_wdata) check("m_wdata", m_wdata, e.wdata);
            if (wcnt >= e.waits) begin
              m_ack   = 1'b1;
              m_rdata = mem_rd(e.addr);
              void'(mem_q.pop_front());
              wcnt    = 0;
            end else begin
              m_ack   = 1'b0;
              m_rdata = 32'h0BAD_0BAD;
              wcnt++;
            end
          end
        end else begin
          m_ack   = spur_ack;
          m_rdata = 32'hFFFF_0000;
          wcnt    = 0;
        end

        if (if_ready || d_ready) begin
          check("ready_exclusive", if_ready & d_ready, 0);
          if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready if_ready=%0b d_ready=%0b expected none", if_ready, d_ready);
          end else begin
            r = rsp_q.pop_front();
            check("ready_owner_is_fetch", if_ready, r.fetch);
            if (r.chk_rdata) check("rdata", r.fetch ? if_rdata : d_rdata, r.rdata);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    mem_q.delete();
    rsp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int rdy;
    rdy = -1;
    @(posedge clk);
    #1;
    if (v.fetch) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_wr    = v.wr;
      d_addr  = v.addr;
      d_wdata = v.wdata;
      d_size  = v.size;
    end
    push_txn(v.fetch, v.wr, v.addr, v.wdata, v.size, v.waits);
    for (int c = 0; c < 60 && rdy < 0; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, "_stall_c0"}, pipe_stall, 1);
      if (c == 1) begin
        check({tag, "_stall_c1"}, pipe_stall, 1);
        check({tag, "_mreq_c1"}, m_req, 1);
      end
      if (v.fetch ? if_ready : d_ready) begin
        rdy = c;
        check({tag, "_stall_at_ready"}, pipe_stall, 0);
      end
    end
    check({tag, "_ready_cycle"}, 64'(rdy), 64'(v.ready_cyc));
    @(posedge clk);
    #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    check({tag, "_ready_one_cycle"}, if_ready | d_ready, 0);
    check({tag, "_idle_no_mreq"}, m_req, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_rdy, f_mreq, f_rdy, nd, nf, dbf, rcyc;
    logic [15:0] pf, pd;
    bit upd_d, upd_f;

    reset   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_size  = '0;

    //            fetch wr    addr          wdata          size         waits rdy
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'b0000,     0,    2};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0001,     2,    4};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         4'(1 << LB), 1,    3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'b0000,     3,    5};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0084, 32'h0,         4'(1 << LH), 0,    2};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0088, 32'hCAFE_F00D, 4'(1 << SH), 0,    2};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wr", m_wr, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_perf_f", perf_fetch_wait, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Single transactions.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Acks outside FETCH/DATA (cycle 0 in IDLE and the RESP cycle) are ignored.
    spur_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("spur_idle_mreq", m_req, 0);
      check("spur_idle_ready", if_ready | d_ready, 0);
    end
    run_vec('{1'b0, 1'b0, 32'h0000_0090, 32'h0, 4'b0000, 2, 4}, "spur");
    spur_ack = 1'b0;

    // Simultaneous requests: data (3 waits) first, then fetch (1 wait).
    apply_reset();
    @(posedge clk);
    #1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0120;
    d_req   = 1'b1;
    d_wr    = 1'b0;
    d_addr  = 32'h0000_0200;
    d_size  = 4'b0000;
    push_txn(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'b0000, 3);
    push_txn(1'b1, 1'b0, 32'h0000_0120, 32'h0, 4'b0000, 1);
    d_rdy = -1; f_mreq = -1; f_rdy = -1; pf = '1; pd = '1;
    for (int c = 0; c < 40 && f_rdy < 0; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (d_rdy >= 0) d_req = 1'b0;
      end
      @(negedge clk);
      if (d_ready) d_rdy = c;
      if (d_rdy >= 0 && c > d_rdy && m_req && f_mreq < 0) f_mreq = c;
      if (if_ready) begin
        f_rdy = c;
        pf    = perf_fetch_wait;
        pd    = perf_data_wait;
      end
    end
    check("sim_d_ready_cyc", 64'(d_rdy), 5);
    check("sim_f_mreq_cyc", 64'(f_mreq), 7);
    check("sim_f_ready_cyc", 64'(f_rdy), 9);
`ifdef MEM_ARB_PERF_EN
    check("perf_data_wait", pd, 5);
    check("perf_fetch_wait", pf, 9);
`else
    check("perf_data_wait", pd, 0);
    check("perf_fetch_wait", pf, 0);
`endif
    @(posedge clk);
    #1;
    if_req = 1'b0;

    // Starvation guard: 6 loads against a held fetch.
    @(posedge clk);
    #1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0300;
    d_req   = 1'b1;
    d_wr    = 1'b0;
    d_size  = 4'b0000;
    d_addr  = 32'h0000_0400;
    for (int k = 0; k < 4; k++) push_txn(1'b0, 1'b0, 32'h0000_0400 + 32'(4 * k), 32'h0, 4'b0000, 0);
    push_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'b0000, 0);
    for (int k = 4; k < 6; k++) push_txn(1'b0, 1'b0, 32'h0000_0400 + 32'(4 * k), 32'h0, 4'b0000, 0);
    nd = 0; nf = 0; dbf = -1; upd_d = 1'b0; upd_f = 1'b0;
    for (int c = 0; c < 100 && (d_req || if_req); c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (upd_d) begin
          if (nd < 6) d_addr = 32'h0000_0400 + 32'(4 * nd);
          else d_req = 1'b0;
          upd_d = 1'b0;
        end
        if (upd_f) begin
          if_req = 1'b0;
          upd_f  = 1'b0;
        end
      end
      @(negedge clk);
      if (d_ready) begin
        nd++;
        upd_d = 1'b1;
      end
      if (if_ready) begin
        nf++;
        if (dbf < 0) dbf = nd;
        upd_f = 1'b1;
      end
    end
    check("starve_data_count", 64'(nd), 6);
    check("starve_fetch_count", 64'(nf), 1);
    check("starve_data_before_fetch", 64'(dbf), MAXD);

    // Asynchronous reset in the middle of a store.
    @(posedge clk);
    #1;
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 32'h0000_0044;
    d_wdata = 32'hA5A5_A5A5;
    d_size  = 4'b0010;
    push_txn(1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 4'b0010, 20);
    repeat (3) @(negedge clk);
    check("mid_mreq_before_rst", m_req, 1);
    #2;
    reset   = 1'b0;
    d_req   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0500;
    mem_q.delete();
    rsp_q.delete();
    #1;
    check("arst_m_req", m_req, 0);
    check("arst_m_wr", m_wr, 0);
    check("arst_m_addr", m_addr, 0);
    check("arst_m_wdata", m_wdata, 0);
    check("arst_m_size", m_size, 0);
    check("arst_if_rdata", if_rdata, 0);
    check("arst_d_rdata", d_rdata, 0);
    check("arst_ready", if_ready | d_ready, 0);
    check("arst_perf", {perf_fetch_wait, perf_data_wait}, 0);
    push_txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'b0000, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    rcyc  = -1;
    for (int c = 0; c < 20 && rcyc < 0; c++) begin
      @(negedge clk);
      if (if_ready) rcyc = c;
    end
    check("post_rst_fetch_ready_cyc", 64'(rcyc), 2);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    check("final_mem_q_drained", 64'(mem_q.size()), 0);
    check("final_rsp_q_drained", 64'(rsp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter
